// File: rtl/cr_mux_rr_arb.sv
// cr_mux_rr_arb: round-robin arbiter driving a shared AND-OR mux between
// N valid/ready requesters and a single sink channel.
// The grant is combinational from in_valid and the rotating pointer. Once a
// beat stalls, the grant is held until that beat completes.
// Optional build macro: CR_MUX_RR_ARB_PKT_EN. When it is defined, a grant is
// held from the first beat of a packet through its eop beat. When it is not
// defined, arbitration happens on every beat and in_eop only feeds out_eop.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_OPEN | grant follows the round-robin search starting at ptr_q
// ST_LOCK | grant pinned to lock_gnt_q (stalled beat or open packet)
module cr_mux_rr_arb #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_eop,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_eop,
  input  logic            out_ready,
  output logic [N-1:0]    out_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  lock_gnt_q, lock_gnt_d;

  logic [N-1:0]  rr_gnt;
  logic [N-1:0]  grant;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] ptr_nxt;
  logic          xfer;
  logic          lock_drop;

  // Rotating priority search: the first valid requester at or after ptr_q wins.
  always_comb begin
    logic found;
    int   idx;
    rr_gnt = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && in_valid[idx]) begin
        rr_gnt[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // The effective grant is forced to zero while reset is asserted, so every
  // output is quiet even when requesters are already driving valid.
  always_comb begin
    grant = '0;
    if (rst_n) begin
      grant = (state_q == ST_LOCK) ? lock_gnt_q : rr_gnt;
    end
  end

  // Encode the one-hot grant to an index and compute the wrapped successor.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        win_idx = PW'(i);
      end
    end
    ptr_nxt = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
  end

  // AND-OR datapath: at most one grant term is non-zero.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data = out_data | (in_data[i*DW +: DW] & {DW{grant[i]}});
    end
  end

  assign out_eop   = |(in_eop & grant);
  assign out_valid = |(in_valid & grant);
  assign in_ready  = grant & {N{out_ready}};
  assign out_grant = grant;
  assign xfer      = out_valid & out_ready;

  // A locked requester that lets go of valid before its beat moves is a
  // protocol error. The lock is released and the pointer is left unchanged.
  assign lock_drop = (state_q == ST_LOCK) && !(|(in_valid & lock_gnt_q));

  // Next-state logic for the lock FSM and the round-robin pointer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_gnt_d = lock_gnt_q;
    if (lock_drop) begin
      state_d    = ST_OPEN;
      lock_gnt_d = '0;
    end else if (out_valid && !out_ready) begin
      state_d    = ST_LOCK;
      lock_gnt_d = grant;
    end else if (xfer) begin
`ifdef CR_MUX_RR_ARB_PKT_EN
      if (!out_eop) begin
        state_d    = ST_LOCK;
        lock_gnt_d = grant;
      end else begin
        state_d    = ST_OPEN;
        lock_gnt_d = '0;
        ptr_d      = ptr_nxt;
      end
`else
      state_d    = ST_OPEN;
      lock_gnt_d = '0;
      ptr_d      = ptr_nxt;
`endif
    end
  end

  // State register. Asserting reset drops any in-flight lock at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OPEN;
      ptr_q      <= '0;
      lock_gnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_gnt_q <= lock_gnt_d;
    end
  end

endmodule

// File: tb/tb_cr_mux_rr_arb.sv
// Bench for cr_mux_rr_arb. The main instance is N=4/DW=32 and a second
// instance is N=3/DW=8. Expected beats are queued as each cycle is driven.
// They are popped and compared against the combinational outputs half a
// clock later.
module tb_cr_mux_rr_arb;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_eop;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_eop;
  logic         out_ready;
  logic [3:0]   out_grant;

  logic [2:0]   v3;
  logic [23:0]  d3;
  logic [2:0]   e3;
  logic [2:0]   r3;
  logic         ov3;
  logic [7:0]   od3;
  logic         oe3;
  logic         ordy3;
  logic [2:0]   g3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    string       tag;
    logic [3:0]  gnt;
    logic        vld;
    logic [31:0] data;
    logic        eop;
    logic [3:0]  rdy;
  } exp_t;

  exp_t sb_q[$];

  cr_mux_rr_arb #(.N(4), .DW(32)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_eop   (out_eop),
    .out_ready (out_ready),
    .out_grant (out_grant)
  );

  cr_mux_rr_arb #(.N(3), .DW(8)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v3),
    .in_data   (d3),
    .in_eop    (e3),
    .in_ready  (r3),
    .out_valid (ov3),
    .out_data  (od3),
    .out_eop   (oe3),
    .out_ready (ordy3),
    .out_grant (g3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dword(input int i, input int c);
    return 32'hC0DE_0000 | (32'(i) << 12) | (32'(c) & 32'h0000_0FFF);
  endfunction

  task automatic set_data();
    for (int i = 0; i < 4; i++) begin
      in_data[i*32 +: 32] = dword(i, cyc);
    end
    d3 = {8'h30, 8'h20, 8'h10} | {3{8'(cyc & 15)}};
  endtask

  // One cycle on the N=4 instance. The expectation is built from the
  // stimulus and the intended grant, queued, then popped at the negedge.
  task automatic step4(input string tag, input logic [3:0] v, input logic [3:0] e,
                       input logic ordy, input logic [3:0] exp_g);
    exp_t ent;
    exp_t got_ent;
    cyc++;
    in_valid  = v;
    in_eop    = e;
    out_ready = ordy;
    set_data();
    ent.tag  = tag;
    ent.gnt  = exp_g;
    ent.vld  = |(v & exp_g);
    ent.eop  = |(e & exp_g);
    ent.rdy  = exp_g & {4{ordy}};
    ent.data = '0;
    for (int i = 0; i < 4; i++) begin
      if (exp_g[i]) ent.data = dword(i, cyc);
    end
    sb_q.push_back(ent);
    @(negedge clk);
    got_ent = sb_q.pop_front();
    chk({got_ent.tag, "_gnt"},  64'(out_grant), 64'(got_ent.gnt));
    chk({got_ent.tag, "_vld"},  64'(out_valid), 64'(got_ent.vld));
    chk({got_ent.tag, "_data"}, 64'(out_data),  64'(got_ent.data));
    chk({got_ent.tag, "_eop"},  64'(out_eop),   64'(got_ent.eop));
    chk({got_ent.tag, "_rdy"},  64'(in_ready),  64'(got_ent.rdy));
    @(posedge clk);
    #1;
  endtask

  // One transferring cycle on the N=3 instance (eop held high on all lanes).
  task automatic step3(input string tag, input logic [2:0] v, input logic [2:0] exp_g);
    logic [7:0] exp_d;
    cyc++;
    v3    = v;
    e3    = 3'b111;
    ordy3 = 1'b1;
    set_data();
    exp_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (exp_g[i]) exp_d = d3[i*8 +: 8];
    end
    @(negedge clk);
    chk({tag, "_gnt"},  64'(g3),  64'(exp_g));
    chk({tag, "_vld"},  64'(ov3), 64'(|(v & exp_g)));
    chk({tag, "_data"}, 64'(od3), 64'(exp_d));
    chk({tag, "_rdy"},  64'(r3),  64'(exp_g));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    v3       = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_eop    = 4'hF;
    out_ready = 1'b1;
    in_data   = '0;
    v3        = 3'b111;
    e3        = 3'b111;
    ordy3     = 1'b1;
    d3        = '0;
    set_data();

    // Reset asserted while all requesters are valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",  64'(out_grant), 64'h0);
    chk("rst_vld",  64'(out_valid), 64'h0);
    chk("rst_rdy",  64'(in_ready),  64'h0);
    chk("rst_data", 64'(out_data),  64'h0);
    chk("rst_gnt3", 64'(g3),        64'h0);
    v3 = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four valid with a free-running sink rotate one grant per clock.
    step4("t2_a", 4'hF, 4'hF, 1'b1, 4'b0001);
    step4("t2_b", 4'hF, 4'hF, 1'b1, 4'b0010);
    step4("t2_c", 4'hF, 4'hF, 1'b1, 4'b0100);
    step4("t2_d", 4'hF, 4'hF, 1'b1, 4'b1000);
    step4("t2_e", 4'hF, 4'hF, 1'b1, 4'b0001);
    step4("t2_f", 4'hF, 4'hF, 1'b1, 4'b0010);

    // Stalled grant holds even when a higher-priority request appears.
    do_reset();
    step4("t3_s1",  4'b0110, 4'hF, 1'b0, 4'b0010);
    step4("t3_s2",  4'b0110, 4'hF, 1'b0, 4'b0010);
    step4("t3_s3",  4'b0110, 4'hF, 1'b0, 4'b0010);
    step4("t3_s4",  4'b0111, 4'hF, 1'b0, 4'b0010);
    step4("t3_go",  4'b0111, 4'hF, 1'b1, 4'b0010);
    step4("t3_nxt", 4'b0111, 4'hF, 1'b1, 4'b0100);
    step4("t3_wrp", 4'b0111, 4'hF, 1'b1, 4'b0001);

    // Non-power-of-2 instance: pointer wraps from N-1 and from the winner.
    do_reset();
    step3("t4_a", 3'b010, 3'b010);
    step3("t4_b", 3'b001, 3'b001);
    step3("t4_c", 3'b111, 3'b010);
    step3("t4_d", 3'b111, 3'b100);
    step3("t4_e", 3'b111, 3'b001);
    v3 = '0;

    // req0 sends a three-beat packet while req1 keeps asking.
    do_reset();
`ifdef CR_MUX_RR_ARB_PKT_EN
    step4("t5_b1", 4'b0011, 4'b0010, 1'b1, 4'b0001);
    step4("t5_b2", 4'b0011, 4'b0010, 1'b1, 4'b0001);
    step4("t5_b3", 4'b0011, 4'b0011, 1'b1, 4'b0001);
    step4("t5_r1", 4'b0010, 4'b0010, 1'b1, 4'b0010);
`else
    step4("t5_b1", 4'b0011, 4'b0010, 1'b1, 4'b0001);
    step4("t5_r1", 4'b0011, 4'b0010, 1'b1, 4'b0010);
    step4("t5_b2", 4'b0011, 4'b0010, 1'b1, 4'b0001);
    step4("t5_r2", 4'b0011, 4'b0010, 1'b1, 4'b0010);
    step4("t5_b3", 4'b0011, 4'b0011, 1'b1, 4'b0001);
`endif

    // Locked req2 abandons its beat: valid drops, lock clears, ptr unchanged.
    do_reset();
    step4("t6_pre",  4'b0001, 4'hF, 1'b1, 4'b0001);
    step4("t6_lock", 4'b0100, 4'hF, 1'b0, 4'b0100);
    step4("t6_drop", 4'b0011, 4'hF, 1'b0, 4'b0100);
    step4("t6_rarb", 4'b0011, 4'hF, 1'b1, 4'b0010);

    // Reset in the middle of a stalled beat clears the lock immediately.
    step4("t7_lock", 4'b0100, 4'hF, 1'b0, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_gnt", 64'(out_grant), 64'h0);
    chk("t7_rst_vld", 64'(out_valid), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step4("t7_after", 4'b0110, 4'hF, 1'b1, 4'b0010);

    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
